// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch front end for decode_stage. Aligned 32-bit words are read
// from instruction memory, which has a fixed 1-cycle latency. The bytes go into
// an 8-byte queue. The oldest five queue bytes are presented as a 40-bit
// instruction window together with their PC. Decode reports how many bytes the
// current instruction uses, and the queue advances by that many bytes when the
// window is accepted. Execute can redirect to any byte address. An accepted
// HALT stops fetching until reset.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   imem_req        read request this cycle
//   imem_addr       word-aligned read address
//   imem_rdata      data for the previous cycle's request, little endian
//   out_valid       instruction window valid
//   out_ready       downstream accepts the window this cycle
//   instr           oldest queue byte in [39:32] ... fifth byte in [7:0]
//   pc              byte address of instr[39:32]
//   consume_len     byte length of the current instruction
//                   (0 is treated as 1; values above 5 are treated as 5)
//   halt            current instruction is HALT
//   redirect        jump taken: flush and restart at redirect_pc
//   redirect_pc     jump target, any byte alignment
//   halted          fetch stopped after an accepted HALT
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] instr,
  output logic [31:0] pc,
  input  logic [7:0]  consume_len,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t      state;
  logic [7:0]  q [8];
  logic [7:0]  q_next [8];
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic [3:0]  base;
  logic [3:0]  shift_len;
  logic [3:0]  src;
  logic [3:0]  pos;
  logic [2:0]  resp_bytes;
  logic        inflight;
  logic        squash;
  logic [1:0]  drop;
  logic [31:0] fetch_addr;
  logic        accept;
  logic        resp_valid;

  assign imem_addr  = fetch_addr;
  assign halted     = (state == ST_HALTED);
  assign out_valid  = (state == ST_RUN) && (count >= 4'd5) && !redirect;
  assign accept     = out_valid && out_ready;
  assign resp_valid = inflight && !squash;

  // A request is issued only if the queue can take its four bytes. The four
  // bytes of a response still in flight are counted as already in the queue.
  // With this rule count can never pass 8.
  assign imem_req = !rst && (state == ST_RUN) && !redirect &&
                    ((count + (inflight ? 4'd4 : 4'd0)) <= 4'd4);

  // Bytes consumed this cycle: 0 when there is no accept, else the clamped length.
  always_comb begin
    if (!accept) begin
      shift_len = 4'd0;
    end else if (consume_len == 8'd0) begin
      shift_len = 4'd1;
    end else if (consume_len > 8'd5) begin
      shift_len = 4'd5;
    end else begin
      shift_len = consume_len[3:0];
    end
  end

  // First shift out the consumed bytes. Then append the response behind the
  // bytes that remain, skipping the 'drop' low bytes after a misaligned
  // redirect.
  always_comb begin
    base       = count - shift_len;
    resp_bytes = 3'd4 - {1'b0, drop};
    src        = 4'd0;
    pos        = 4'd0;
    for (int i = 0; i < 8; i++) begin
      src       = 4'(i) + shift_len;
      q_next[i] = src[3] ? 8'h00 : q[src[2:0]];
    end
    count_next = base;
    if (resp_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= drop) begin
          pos = base + 4'(k) - {2'b00, drop};
          if (!pos[3]) begin
            q_next[pos[2:0]] = imem_rdata[8*k +: 8];
          end
        end
      end
      count_next = base + {1'b0, resp_bytes};
    end
  end

  // Slots at or above count read as zero, so stale bytes never reach decode.
  always_comb begin
    instr = 40'd0;
    for (int i = 0; i < 5; i++) begin
      instr[39-8*i -: 8] = (4'(i) < count) ? q[i] : 8'h00;
    end
  end

  // Redirect takes priority over accept and response. A response that arrives
  // in the redirect cycle is lost because the queue is not updated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      count      <= 4'd0;
      inflight   <= 1'b0;
      squash     <= 1'b0;
      drop       <= RESET_PC[1:0];
      pc         <= RESET_PC;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      for (int i = 0; i < 8; i++) begin
        q[i] <= 8'h00;
      end
    end else if (state == ST_HALTED) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (redirect) begin
      count      <= 4'd0;
      pc         <= redirect_pc;
      fetch_addr <= {redirect_pc[31:2], 2'b00};
      drop       <= redirect_pc[1:0];
      inflight   <= 1'b0;
      squash     <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        q[i] <= q_next[i];
      end
      count    <= count_next;
      pc       <= pc + {28'd0, shift_len};
      inflight <= imem_req;
      squash   <= 1'b0;
      if (imem_req) begin
        fetch_addr <= fetch_addr + 32'd4;
      end
      if (resp_valid) begin
        drop <= 2'b00;
      end
      if (accept && halt) begin
        state <= ST_HALTED;
      end
    end
  end

endmodule
